nv_ram_rws_param: RTL

NV_RAM_RWS_PARAM -- requirements
Module: nv_ram_rws_param

---
 rtl/nv_ram_rws_param.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/nv_ram_rws_param.sv
// nv_ram_rws_param: single-clock RAM with one read port and one write port.
//
// Purpose
//   DEPTH x DW storage, write-first on same-address read/write. After reset an
//   optional init sequence zero-fills the array one entry per cycle, and
//   accesses are ignored while init_busy is high.
//
// Parameters
//   DW            data width (1..256)
//   DEPTH         number of entries (2..4096, any value)
//   AW            address width, must equal ceil(log2(DEPTH))
//   CLR_ON_RESET  1: zero-fill the array after reset, 0: no fill
//
// Ports
//   clk            clock, rising edge
//   rst            asynchronous active-high reset
//   ra, re         read address / read enable
//   dout, dout_vld read data / one-cycle valid per accepted read
//   wa, we, di     write address / write enable / write data
//   pwrbus_ram_pd  power-down bus, no functional effect
//   init_busy      array clear in progress
//
// Build option
//   NV_RAM_RWS_OREG_EN  adds an output register: read latency 2, dout held
//                       between reads instead of tracking later writes.
module nv_ram_rws_param #(
  parameter int unsigned DW           = 18,
  parameter int unsigned DEPTH        = 128,
  parameter int unsigned AW           = 7,
  parameter bit          CLR_ON_RESET = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] ra,
  input  logic          re,
  output logic [DW-1:0] dout,
  output logic          dout_vld,
  input  logic [AW-1:0] wa,
  input  logic          we,
  input  logic [DW-1:0] di,
  input  logic [31:0]   pwrbus_ram_pd,
  output logic          init_busy
);

  typedef enum logic [1:0] {StRst, StClear, StReady} init_state_e;

  localparam int unsigned LastIdx  = DEPTH - 1;
  localparam logic [AW:0] DepthW   = DEPTH[AW:0];
  localparam logic [AW-1:0] LastAddr = LastIdx[AW-1:0];

  logic [DW-1:0] mem [DEPTH];

  init_state_e   state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic          clr_we;

  logic          wr_ok;
  logic          rd_ok;
  logic [AW-1:0] ra_q;
  logic          ra_hit_q;   // an accepted read exists and its address was in range
  logic          vld_q;
  logic [DW-1:0] rd_data;

  logic          unused_pd;
  assign unused_pd = ^pwrbus_ram_pd;

  // Init FSM
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StRst;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    clr_we  = 1'b0;
    unique case (state_q)
      StRst: begin
        state_d = CLR_ON_RESET ? StClear : StReady;
      end
      StClear: begin
        clr_we = 1'b1;
        if (cnt_q == LastAddr) begin
          state_d = StReady;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StReady: begin
        state_d = StReady;
      end
      default: begin
        state_d = StRst;
      end
    endcase
  end

  assign init_busy = (state_q == StClear) || ((state_q == StRst) && CLR_ON_RESET);

  // Storage: no reset; only the init clear or an accepted write touch it.
  assign wr_ok = we && !init_busy && ({1'b0, wa} < DepthW);

  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem[cnt_q] <= '0;
    end else if (wr_ok) begin
      mem[wa] <= di;
    end
  end

  // Read address register. The array is read combinationally from ra_q, so a
  // write at the acceptance edge is visible (write-first) and later writes to
  // ra_q show through until the next read.
  assign rd_ok = re && !init_busy;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ra_q     <= '0;
      ra_hit_q <= 1'b0;
      vld_q    <= 1'b0;
    end else begin
      vld_q <= rd_ok;
      if (rd_ok) begin
        ra_q     <= ra;
        ra_hit_q <= ({1'b0, ra} < DepthW);
      end
    end
  end

  assign rd_data = ra_hit_q ? mem[ra_q] : '0;

`ifdef NV_RAM_RWS_OREG_EN
  logic [DW-1:0] dout_q;
  logic          dout_vld_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout_q     <= '0;
      dout_vld_q <= 1'b0;
    end else begin
      dout_vld_q <= vld_q;
      if (vld_q) begin
        dout_q <= rd_data;
      end
    end
  end

  assign dout     = dout_q;
  assign dout_vld = dout_vld_q;
`else
  assign dout     = rd_data;
  assign dout_vld = vld_q;
`endif

endmodule
